instruction_fetch: RTL
======================

# instruction_fetch

Pipeline IF stage for the MIPS core. It owns the program counter, drives the instruction-memory address, and captures the returned word into the IF/ID register. It honours stall, flush and redirect requests from later stages. Optionally it predicts jumps and backward branches statically, so tight loops refetch without a bubble.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IMEM_WORDS, 256, instruction-memory depth in words. The valid fetch range is 0 .. IMEM_WORDS*4-4.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- imem_addr  out  32  byte address to instruction memory; always equals the PC.
- imem_instr  in  32  combinational read data for imem_addr.
- stall  in  1  hold PC and IF/ID (load-use hazard from ID).
- flush  in  1  squash the IF/ID slot being written this edge.
- redirect_valid  in  1  load the PC from redirect_pc (branch resolution, jr, mispredict repair).
- redirect_pc  in  32  redirect target.
- ifid_instr  out  32  registered instruction.
- ifid_pc_plus4  out  32  registered PC+4 of that instruction.
- ifid_valid  out  1  IF/ID slot holds a real instruction.
- ifid_pred_taken  out  1  fetch predicted this instruction taken.
- fetch_fault  out  1  sticky flag for a misaligned or out-of-range PC.

## Operation
- Each edge, next-PC priority is: reset > redirect_valid > fault hold > stall > prediction > PC+4.
- **Redirect:** PC <= redirect_pc. The IF/ID slot is squashed (valid 0, instr 0). fetch_fault clears. Redirect overrides stall.
- **Stall (no redirect):** PC and all IF/ID outputs hold. If flush is also asserted, IF/ID valid clears and the PC still holds.
- **Flush alone:** PC advances normally; the slot written this edge has valid 0.
- **Normal:** IF/ID captures imem_instr, PC+4 and the prediction bit, with valid 1.
- **Fault:** raised when PC[1:0] != 0 or PC >= IMEM_WORDS*4.
  - The captured slot is invalid.
  - fetch_fault sets.
  - The PC holds until a redirect arrives.
- A squashed or invalid slot always shows ifid_instr = 0 (nop) and ifid_pred_taken = 0.
- PC arithmetic is modulo 2^32 with no saturation.

## Timing
- Reset values:
  - PC = RESET_PC
  - ifid_instr = 0
  - ifid_pc_plus4 = 0
  - ifid_valid = 0
  - ifid_pred_taken = 0
  - fetch_fault = 0
- Reset takes effect immediately on assertion, including mid-stall or mid-redirect. The first fetch uses RESET_PC on the first edge after release.
- Latency is one cycle: the word at imem_addr during cycle N appears on ifid_* after the edge ending cycle N.
- Throughput is one instruction per cycle with no stall, fault or redirect.
- A redirect costs the squashed slot. The target's instruction is valid two edges after redirect_valid is sampled.
- Memory read is combinational within the cycle. No handshake with the memory.

## Configuration
- STATIC_BTFN_EN defined: the fetched word is decoded in IF.
  - opcode 6'h02/6'h03 (j/jal): next PC = {PC+4[31:28], instr[25:0], 2'b00}, pred_taken 1.
  - opcode 6'h04/6'h05 (beq/bne) with instr[15] = 1: next PC = PC+4 + (sext(instr[15:0]) << 2), pred_taken 1.
  - Forward branches are predicted not-taken.
  - Downstream repairs mispredictions via redirect.
- STATIC_BTFN_EN undefined:
  - Next PC is always PC+4.
  - ifid_pred_taken is tied 0.
  - Jumps and branches resolve via redirect.

## Structure
- Package mips_pkg holds:
  - opcode constants OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04, OP_BNE = 6'h05, OP_ESW = 6'h3F
  - NOP = 32'h0
  - RESET_PC default
- Sub-module fetch_predictor: combinational; inputs pc and instr; outputs pred_taken and pred_pc. It is instantiated only under STATIC_BTFN_EN.

## Test plan
- **Reset mid-run:** drop rst_n at PC 0x14, then release.
  - imem_addr = 0, ifid_valid = 0.
  - After the first edge: ifid_instr = 0x00102021, ifid_pc_plus4 = 0x4, valid 1.
- **Stall:** assert stall for 2 cycles with PC at 0x8.
  - imem_addr stays 0x8 and IF/ID holds.
  - After release, 0xC is fetched next.
- **Redirect and stall together:** redirect_pc = 0x20 with stall high.
  - Next imem_addr = 0x20, ifid_valid = 0.
  - Following edge: ifid_pc_plus4 = 0x24.
- **Prediction (STATIC_BTFN_EN on):**
  - 0x1000FFFB at 0x1C: next imem_addr = 0xC, pred_taken 1.
  - 0x0C000008 at 0x08: next imem_addr = 0x20.
  - Macro off: the same words give 0x20 and 0x0C, pred_taken 0.
- **Fault:** redirect_pc = 0x402.
  - ifid_valid = 0, fetch_fault = 1, imem_addr holds 0x402.
  - redirect_pc = 0x0 clears the fault and fetch resumes.
- **Flush alone at PC 0x10:** imem_addr advances to 0x14 and ifid_valid = 0 for that slot.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS core front end.
package mips_pkg;

  localparam logic [5:0]  OP_J   = 6'h02;
  localparam logic [5:0]  OP_JAL = 6'h03;
  localparam logic [5:0]  OP_BEQ = 6'h04;
  localparam logic [5:0]  OP_BNE = 6'h05;
  localparam logic [5:0]  OP_ESW = 6'h3F;

  localparam logic [31:0] NOP              = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Source of the next PC, listed in decreasing priority.
  typedef enum logic [2:0] {
    SEL_REDIRECT,
    SEL_FAULT,
    SEL_STALL,
    SEL_PRED,
    SEL_SEQ
  } pc_sel_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_plus4;
    logic        valid;
    logic        pred_taken;
  } ifid_t;

  // An empty slot always presents a nop with no prediction.
  function automatic ifid_t squash_slot(input ifid_t s);
    ifid_t r;
    r            = s;
    r.instr      = NOP;
    r.valid      = 1'b0;
    r.pred_taken = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/fetch_predictor.sv
// Static backward-taken/forward-not-taken predictor for jumps and branches.
module fetch_predictor
  import mips_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] instr,
  output logic        pred_taken,
  output logic [31:0] pred_pc
);

  logic [31:0] pc_plus4;
  logic [5:0]  opcode;
  logic [31:0] br_offset;

  assign pc_plus4  = pc + 32'd4;
  assign opcode    = instr[31:26];
  assign br_offset = {{14{instr[15]}}, instr[15:0], 2'b00};

  always_comb begin
    pred_taken = 1'b0;
    pred_pc    = pc_plus4;
    if ((opcode == OP_J) || (opcode == OP_JAL)) begin
      pred_taken = 1'b1;
      pred_pc    = {pc_plus4[31:28], instr[25:0], 2'b00};
    end else if (((opcode == OP_BEQ) || (opcode == OP_BNE)) && instr[15]) begin
      pred_taken = 1'b1;
      pred_pc    = pc_plus4 + br_offset;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// IF stage: PC, instruction-memory address and IF/ID register.
// Define STATIC_BTFN_EN to enable static jump/backward-branch prediction.
module instruction_fetch
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int unsigned IMEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc_plus4,
  output logic        ifid_valid,
  output logic        ifid_pred_taken,
  output logic        fetch_fault
);

  localparam logic [31:0] IMEM_LIMIT = 32'(IMEM_WORDS * 4);

  logic [31:0] pc_q, pc_d;
  ifid_t       ifid_q, ifid_d;
  logic        fault_q, fault_d;

  logic [31:0] pc_plus4;
  logic        fault_now;
  logic        pred_taken_w;
  logic [31:0] pred_pc_w;
  pc_sel_e     sel;
  ifid_t       slot_new;

  assign pc_plus4  = pc_q + 32'd4;
  assign fault_now = (pc_q[1:0] != 2'b00) || (pc_q >= IMEM_LIMIT);

`ifdef STATIC_BTFN_EN
  fetch_predictor u_predictor (
    .pc         (pc_q),
    .instr      (imem_instr),
    .pred_taken (pred_taken_w),
    .pred_pc    (pred_pc_w)
  );
`else
  assign pred_taken_w = 1'b0;
  assign pred_pc_w    = pc_plus4;
`endif

  always_comb begin
    sel = SEL_SEQ;
    if (redirect_valid)           sel = SEL_REDIRECT;
    else if (fault_now || fault_q) sel = SEL_FAULT;
    else if (stall)               sel = SEL_STALL;
    else if (pred_taken_w)        sel = SEL_PRED;
  end

  always_comb begin
    slot_new            = '0;
    slot_new.instr      = imem_instr;
    slot_new.pc_plus4   = pc_plus4;
    slot_new.valid      = 1'b1;
    slot_new.pred_taken = pred_taken_w;

    pc_d    = pc_q;
    ifid_d  = ifid_q;
    fault_d = fault_q;
    unique case (sel)
      SEL_REDIRECT: begin
        pc_d    = redirect_pc;
        ifid_d  = squash_slot(slot_new);
        fault_d = 1'b0;
      end
      SEL_FAULT: begin
        ifid_d  = squash_slot(slot_new);
        fault_d = 1'b1;
      end
      SEL_STALL: begin
        if (flush) ifid_d = squash_slot(ifid_q);
      end
      SEL_PRED: begin
        pc_d   = pred_pc_w;
        ifid_d = flush ? squash_slot(slot_new) : slot_new;
      end
      default: begin
        pc_d   = pc_plus4;
        ifid_d = flush ? squash_slot(slot_new) : slot_new;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      ifid_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      ifid_q  <= ifid_d;
      fault_q <= fault_d;
    end
  end

  assign imem_addr       = pc_q;
  assign ifid_instr      = ifid_q.instr;
  assign ifid_pc_plus4   = ifid_q.pc_plus4;
  assign ifid_valid      = ifid_q.valid;
  assign ifid_pred_taken = ifid_q.pred_taken;
  assign fetch_fault     = fault_q;

endmodule
